wddl_rx_decoder: RTL



---
 rtl/wddl_rx_decoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/wddl_rx_decoder.sv
// WDDL dual-rail receive terminator: tracks precharge/evaluate waves, decodes one
// token per evaluate phase into a single-entry valid/ready buffer and flags codeword faults.
module wddl_rx_decoder #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_p_in,
  input  logic [WIDTH-1:0] d_n_in,
  input  logic             prech_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             err_illegal,
  output logic             err_precharge,
  output logic             err_timeout,
  output logic             overrun
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_PRE  = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] n_q;
  logic           pre_q;
  logic           pre_d;
  logic           z_d;
  logic [CW-1:0]  cnt;

  logic           complete;
  logic           illegal;
  logic           entry;
  logic           eval_act;
  logic           capture;
  logic [CW-1:0]  cur_cnt;

  // Sample decode; the entry sample is evaluated in place as eval sample 1.
  always_comb begin
    complete = &(p_q ^ n_q);
    illegal  = |(p_q & n_q);
    entry    = pre_d & ~pre_q;
    eval_act = (state == S_EVAL) || ((state == S_PRE) && entry && z_d);
    cur_cnt  = (state == S_EVAL) ? cnt : CW'(1);
    capture  = eval_act && !illegal && complete;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q           <= '0;
      n_q           <= '0;
      pre_q         <= 1'b0;
      pre_d         <= 1'b0;
      z_d           <= 1'b0;
      state         <= S_PRE;
      cnt           <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      err_illegal   <= 1'b0;
      err_precharge <= 1'b0;
      err_timeout   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      p_q           <= d_p_in;
      n_q           <= d_n_in;
      pre_q         <= prech_in;
      pre_d         <= pre_q;
      z_d           <= ~|(p_q | n_q);
      err_illegal   <= 1'b0;
      err_precharge <= 1'b0;
      err_timeout   <= 1'b0;
      overrun       <= 1'b0;

      if (eval_act) begin
        if (illegal) begin
          err_illegal <= 1'b1;
          state       <= S_DONE;
        end else if (complete) begin
          state <= S_DONE;
        end else if (pre_q) begin
          err_timeout <= 1'b1;
          state       <= S_PRE;
        end else if (cur_cnt == CW'(TIMEOUT)) begin
          err_timeout <= 1'b1;
          state       <= S_DONE;
        end else begin
          cnt   <= cur_cnt + CW'(1);
          state <= S_EVAL;
        end
      end else begin
        if (illegal) err_illegal <= 1'b1;
        case (state)
          S_PRE: begin
            // Entry reached here only when the last precharge sample was not all-00.
            if (entry) begin
              err_precharge <= 1'b1;
              state         <= S_DONE;
            end
          end
          S_DONE:  if (pre_q) state <= S_PRE;
          default: state <= S_PRE;
        endcase
      end

      // Single-entry output buffer; a capture into a stalled full buffer is dropped.
      if (capture) begin
        if (!valid_out || ready_in) begin
          data_out  <= p_q;
          valid_out <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule
